axi4l_lsu_master: RTL and testbench



---
 rtl/axi4l_pkg.sv | 19 +
 rtl/axi4l_if.sv | 37 +++
 rtl/axi4l_lsu_master.sv | 126 ++++++++++++
 tb/tb_axi4l_lsu_master.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite widths, payload types and response encodings.
package axi4l_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [STRB_W-1:0] strb_t;
  typedef logic [1:0]        resp_t;

  localparam resp_t OKAY   = 2'b00;
  localparam resp_t SLVERR = 2'b10;

  // Clears the byte offset so every bus access is word aligned.
  localparam addr_t ADDR_ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bundle shared by the LSU bridge and the slaves on the interconnect.
interface axi4l_if (
  input logic aclk,
  input logic aresetn
);

  axi4l_pkg::addr_t awaddr;
  logic             awvalid;
  logic             awready;
  axi4l_pkg::data_t wdata;
  axi4l_pkg::strb_t wstrb;
  logic             wvalid;
  logic             wready;
  axi4l_pkg::resp_t bresp;
  logic             bvalid;
  logic             bready;
  axi4l_pkg::addr_t araddr;
  logic             arvalid;
  logic             arready;
  axi4l_pkg::data_t rdata;
  axi4l_pkg::resp_t rresp;
  logic             rvalid;
  logic             rready;

  modport master (
    input  aclk, aresetn,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4l_lsu_master.sv
// Ibex-style req/gnt/rvalid data port to AXI4-Lite master bridge.
// One transaction in flight; bus errors come back on err_o with rvalid_o.
module axi4l_lsu_master
  import axi4l_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic              we_i,
  input  logic [STRB_W-1:0] be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  axi4l_if.master           axi
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

  state_t state_q, state_d;
  addr_t  addr_q;
  data_t  wdata_q;
  strb_t  be_q;
  logic   awvalid_q, wvalid_q, arvalid_q;
  logic   rvalid_q, err_q;
  data_t  rdata_q;
  logic   aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign gnt_o = req_i && (state_q == IDLE);

  assign aw_hs = awvalid_q && axi.awready;
  assign w_hs  = wvalid_q && axi.wready;
  assign ar_hs = arvalid_q && axi.arready;
  // Responses outside their RESP state are protocol violations and are dropped.
  assign b_hs  = (state_q == WR_RESP) && axi.bvalid;
  assign r_hs  = (state_q == RD_RESP) && axi.rvalid;

  // NOTE: assign every always_comb output a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_o) state_d = we_i ? WR_REQ : RD_REQ;
      WR_REQ:  if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) state_d = WR_RESP;
      WR_RESP: if (b_hs) state_d = IDLE;
      RD_REQ:  if (ar_hs) state_d = RD_RESP;
      RD_RESP: if (r_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (gnt_o) begin
        addr_q    <= addr_i & ADDR_ALIGN_MASK;
        wdata_q   <= wdata_i;
        be_q      <= be_i;
        awvalid_q <= we_i;
        wvalid_q  <= we_i;
        arvalid_q <= !we_i;
      end
      // AW and W retire independently; the FSM waits for both.
      if (aw_hs) awvalid_q <= 1'b0;
      if (w_hs)  wvalid_q  <= 1'b0;
      if (ar_hs) arvalid_q <= 1'b0;
      if (b_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= '0;
        err_q    <= (axi.bresp != OKAY);
      end
      if (r_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= axi.rdata;
        err_q    <= (axi.rresp != OKAY);
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  assign axi.awaddr  = addr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = be_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = (state_q == WR_RESP);
  assign axi.araddr  = addr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = (state_q == RD_RESP);

`ifdef FORMAL
  a_aw_hold: assert property (@(posedge clk) disable iff (!rst_n)
    axi.awvalid && !axi.awready |=> axi.awvalid && $stable(axi.awaddr));
  a_w_hold: assert property (@(posedge clk) disable iff (!rst_n)
    axi.wvalid && !axi.wready |=> axi.wvalid && $stable(axi.wdata) && $stable(axi.wstrb));
  a_ar_hold: assert property (@(posedge clk) disable iff (!rst_n)
    axi.arvalid && !axi.arready |=> axi.arvalid && $stable(axi.araddr));
  a_one_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({axi.awvalid || axi.wvalid, axi.arvalid, axi.bready, axi.rready}));
  a_no_stray_b: assert property (@(posedge clk) disable iff (!rst_n)
    axi.bvalid |-> axi.bready);
  a_no_stray_r: assert property (@(posedge clk) disable iff (!rst_n)
    axi.rvalid |-> axi.rready);
`endif

endmodule

// File: tb/tb_axi4l_lsu_master.sv
// Directed bench for axi4l_lsu_master with a wait-state-programmable AXI4-Lite slave.
module tb_axi4l_lsu_master;
  import axi4l_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  axi4l_if axi_bus (.aclk(clk), .aresetn(rst_n));

  axi4l_lsu_master dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .we_i     (we_i),
    .be_i     (be_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .axi      (axi_bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Slave behaviour, programmed by the stimulus before each transaction.
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  logic [31:0] rd_data = '0;
  logic [1:0]  rsp     = OKAY;
  int          b_hs_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Slave reacts at the falling edge so its outputs are settled for the next rising edge.
  initial begin
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.arready = 1'b0;
    axi_bus.bvalid  = 1'b0; axi_bus.bresp  = OKAY;
    axi_bus.rvalid  = 1'b0; axi_bus.rresp  = OKAY; axi_bus.rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.arready = 1'b0;
        axi_bus.bvalid  = 1'b0; axi_bus.rvalid = 1'b0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      end else begin
        if (axi_bus.awvalid) begin
          axi_bus.awready = (aw_cnt >= aw_wait);
          if (aw_cnt < aw_wait) aw_cnt++;
        end else begin
          axi_bus.awready = 1'b0; aw_cnt = 0;
        end
        if (axi_bus.wvalid) begin
          axi_bus.wready = (w_cnt >= w_wait);
          if (w_cnt < w_wait) w_cnt++;
        end else begin
          axi_bus.wready = 1'b0; w_cnt = 0;
        end
        if (axi_bus.arvalid) begin
          axi_bus.arready = (ar_cnt >= ar_wait);
          if (ar_cnt < ar_wait) ar_cnt++;
        end else begin
          axi_bus.arready = 1'b0; ar_cnt = 0;
        end
        if (axi_bus.bready) begin
          axi_bus.bvalid = (b_cnt >= b_wait);
          axi_bus.bresp  = rsp;
          if (b_cnt < b_wait) b_cnt++;
        end else begin
          axi_bus.bvalid = 1'b0; b_cnt = 0;
        end
        if (axi_bus.rready) begin
          axi_bus.rvalid = (r_cnt >= r_wait);
          axi_bus.rdata  = rd_data;
          axi_bus.rresp  = rsp;
          if (r_cnt < r_wait) r_cnt++;
        end else begin
          axi_bus.rvalid = 1'b0; r_cnt = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (axi_bus.bvalid && axi_bus.bready) b_hs_cnt++;
    end
  end

  // Issues one request, drops req after the grant and returns the cycle of rvalid_o.
  task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
    #1 check({tag, "_gnt"}, gnt_o, 1'b1);
    @(negedge clk);
    req_i = 1'b0;
    lat = 1;
    #1;
    while (!rvalid_o && lat < 60) begin
      @(negedge clk);
      #1 lat++;
    end
    rd = rdata_o;
    er = err_o;
  endtask

  initial begin
    int          lat;
    int          b0;
    logic [31:0] rd;
    logic        er;

    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = '0; addr_i = '0; wdata_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_rvalid",  rvalid_o, 1'b0);
    check("rst_err",     err_o, 1'b0);
    check("rst_rdata",   rdata_o, 32'h0);
    check("rst_awvalid", axi_bus.awvalid, 1'b0);
    check("rst_arvalid", axi_bus.arvalid, 1'b0);
    check("rst_bready",  axi_bus.bready, 1'b0);
    rst_n = 1'b1;

    // 1: write, zero-wait slave
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0; wdata_i = 32'hDEAD_BEEF; be_i = 4'hF;
    #1 check("t1_gnt_c0", gnt_o, 1'b1);
    @(negedge clk); req_i = 1'b0;
    #1;
    check("t1_awvalid_c1", axi_bus.awvalid, 1'b1);
    check("t1_wvalid_c1",  axi_bus.wvalid, 1'b1);
    check("t1_awaddr_c1",  axi_bus.awaddr, 32'h0);
    check("t1_wdata_c1",   axi_bus.wdata, 32'hDEAD_BEEF);
    check("t1_wstrb_c1",   axi_bus.wstrb, 4'hF);
    @(negedge clk); #1;
    check("t1_bready_c2", axi_bus.bready, 1'b1);
    check("t1_rvalid_c2", rvalid_o, 1'b0);
    @(negedge clk); #1;
    check("t1_rvalid_c3", rvalid_o, 1'b1);
    check("t1_err_c3",    err_o, 1'b0);
    check("t1_rdata_c3",  rdata_o, 32'h0);

    // 2: read, two R wait states
    r_wait = 2; rd_data = 32'h1234_5678;
    run_txn("t2", 1'b0, 32'h4, 32'h0, 4'hF, lat, rd, er);
    check("t2_lat",   lat, 5);
    check("t2_rdata", rd, 32'h1234_5678);
    check("t2_err",   er, 1'b0);
    r_wait = 0;

    // 3: write, AW delayed by three cycles, unaligned address
    aw_wait = 3;
    b0 = b_hs_cnt;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'hA; wdata_i = 32'hCAFE_F00D; be_i = 4'h3;
    #1 check("t3_gnt_c0", gnt_o, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); req_i = 1'b0;
      #1;
      check($sformatf("t3_awvalid_c%0d", c), axi_bus.awvalid, 1'b1);
      check($sformatf("t3_awaddr_c%0d", c),  axi_bus.awaddr, 32'h8);
      check($sformatf("t3_wvalid_c%0d", c),  axi_bus.wvalid, (c == 1));
      if (c == 1) check("t3_wstrb_c1", axi_bus.wstrb, 4'h3);
    end
    @(negedge clk); #1;
    check("t3_awvalid_c5", axi_bus.awvalid, 1'b0);
    check("t3_bready_c5",  axi_bus.bready, 1'b1);
    @(negedge clk); #1;
    check("t3_rvalid_c6", rvalid_o, 1'b1);
    check("t3_err_c6",    err_o, 1'b0);
    @(negedge clk); #1;
    check("t3_rvalid_c7", rvalid_o, 1'b0);
    check("t3_b_count",   b_hs_cnt - b0, 1);
    aw_wait = 0;

    // 4: error responses on read and write, then a clean read
    rsp = SLVERR; rd_data = 32'h0;
    run_txn("t4_rd_err", 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    check("t4_rd_err_lat", lat, 3);
    check("t4_rd_err_err", er, 1'b1);
    run_txn("t4_wr_err", 1'b1, 32'h18, 32'h55AA_55AA, 4'hF, lat, rd, er);
    check("t4_wr_err_err",   er, 1'b1);
    check("t4_wr_err_rdata", rd, 32'h0);
    rsp = OKAY; rd_data = 32'h0BAD_F00D;
    run_txn("t4_rd_ok", 1'b0, 32'h14, 32'h0, 4'hF, lat, rd, er);
    check("t4_rd_ok_err",   er, 1'b0);
    check("t4_rd_ok_rdata", rd, 32'h0BAD_F00D);

    // 5: request held for two back-to-back reads
    rd_data = 32'h1111_0020;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h20;
    #1 check("t5_gnt_c0", gnt_o, 1'b1);
    @(negedge clk); addr_i = 32'h24;
    #1 check("t5_gnt_c1", gnt_o, 1'b0);
    @(negedge clk); #1;
    check("t5_gnt_c2", gnt_o, 1'b0);
    @(negedge clk); #1;
    check("t5_gnt_c3",    gnt_o, 1'b1);
    check("t5_rvalid_c3", rvalid_o, 1'b1);
    check("t5_rdata_c3",  rdata_o, 32'h1111_0020);
    rd_data = 32'h2222_0024;
    @(negedge clk); req_i = 1'b0;
    #1 check("t5_araddr_c4", axi_bus.araddr, 32'h24);
    @(negedge clk); #1;
    check("t5_rvalid_c5", rvalid_o, 1'b0);
    @(negedge clk); #1;
    check("t5_rvalid_c6", rvalid_o, 1'b1);
    check("t5_rdata_c6",  rdata_o, 32'h2222_0024);

    // 6: reset while waiting for R, with err_o and rdata_o left non-zero beforehand
    rsp = SLVERR; rd_data = 32'h5A5A_5A5A;
    run_txn("t6_pre", 1'b0, 32'h40, 32'h0, 4'hF, lat, rd, er);
    check("t6_pre_err", er, 1'b1);
    rsp = OKAY; r_wait = 5;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h30;
    #1 check("t6_gnt_c0", gnt_o, 1'b1);
    @(negedge clk); req_i = 1'b0;
    #1 check("t6_arvalid_c1", axi_bus.arvalid, 1'b1);
    @(negedge clk); #1;
    check("t6_rready_c2", axi_bus.rready, 1'b1);
    check("t6_err_held",  err_o, 1'b1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_rready",  axi_bus.rready, 1'b0);
    check("t6_rst_arvalid", axi_bus.arvalid, 1'b0);
    check("t6_rst_rvalid",  rvalid_o, 1'b0);
    check("t6_rst_err",     err_o, 1'b0);
    check("t6_rst_rdata",   rdata_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; r_wait = 0; rd_data = 32'h0F0F_1234;
    run_txn("t6_post", 1'b0, 32'h34, 32'h0, 4'hF, lat, rd, er);
    check("t6_post_lat",   lat, 3);
    check("t6_post_rdata", rd, 32'h0F0F_1234);
    check("t6_post_err",   er, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
